// File: rtl/MIDI.sv
// MIDI shared package.
// Holds the note event type handed to the synth pipeline, the ON/OFF status
// enum, the byte class enum produced by the byte classifier, the status
// nibble and system byte constants, and small helpers that describe how many
// data bytes each voice message kind carries.
package MIDI;

  localparam int DATA_WIDTH = 7;

  // Status nibbles of the voice messages (upper nibble of 0x80..0xEF)
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // System bytes
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } note_status_e;

  typedef struct packed {
    note_status_e          status;
    logic [DATA_WIDTH-1:0] note_number;
    logic [DATA_WIDTH-1:0] velocity;
  } note_change_t;

  typedef enum logic [1:0] {
    BC_DATA     = 2'd0,
    BC_VOICE    = 2'd1,
    BC_SYSCOM   = 2'd2,
    BC_REALTIME = 2'd3
  } byte_class_e;

  // Number of data bytes that follow a voice status of the given kind.
  function automatic logic [1:0] voice_data_count(input logic [3:0] kind);
    case (kind)
      PROG, CH_AT:                       return 2'd1;
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: return 2'd2;
      default:                           return 2'd0;
    endcase
  endfunction

  function automatic logic is_note_kind(input logic [3:0] kind);
    return (kind == NOTE_OFF) || (kind == NOTE_ON);
  endfunction

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational MIDI byte classifier.
// Ports:
//   byte_in    - raw MIDI byte
//   byte_class - data / voice status / system common / real-time
//   kind       - status nibble (meaningful for voice status bytes)
//   channel    - low nibble (meaningful for voice status bytes)
//   data_count - data bytes that follow this status byte (0..2);
//                0 for data and real-time bytes
module midi_byte_classifier
  import MIDI::*;
(
  input  logic [7:0]  byte_in,
  output byte_class_e byte_class,
  output logic [3:0]  kind,
  output logic [3:0]  channel,
  output logic [1:0]  data_count
);

  // Class boundaries: bit7 clear is data, 0x80..0xEF voice, 0xF8 and up
  // real-time, the rest system common. Song position (F2) carries two data
  // bytes, MTC quarter frame (F1) and song select (F3) carry one.
  always_comb begin
    byte_class = BC_DATA;
    kind       = byte_in[7:4];
    channel    = byte_in[3:0];
    data_count = 2'd0;
    if (!byte_in[7]) begin
      byte_class = BC_DATA;
    end else if (byte_in < SYSEX_START) begin
      byte_class = BC_VOICE;
      data_count = voice_data_count(byte_in[7:4]);
    end else if (byte_in >= RT_MIN) begin
      byte_class = BC_REALTIME;
    end else begin
      byte_class = BC_SYSCOM;
      case (byte_in)
        8'hF1, 8'hF3: data_count = 2'd1;
        8'hF2:        data_count = 2'd2;
        default:      data_count = 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/midi_note_decoder.sv
// MIDI note decoder.
// Turns the raw byte stream from the UART receiver into note events for the
// synth pipeline. Handles running status, velocity-0 Note On as Note Off,
// real-time bytes interleaved anywhere, and skips all other message types.
// Ports:
//   clock_50_000_000 - system clock
//   reset            - synchronous, active-high reset
//   byte_in          - received MIDI byte
//   byte_valid       - byte_in valid this cycle
//   note             - last decoded event (status, note number, velocity)
//   note_ready       - one-cycle strobe, one cycle after the velocity byte
// Parameters:
//   CHANNEL          - channel accepted when MIDI_CHANNEL_FILTER_EN is defined
// Build option:
//   MIDI_CHANNEL_FILTER_EN - emit only events on CHANNEL; omni when undefined
module midi_note_decoder
  import MIDI::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic         clock_50_000_000,
  input  logic         reset,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output note_change_t note,
  output logic         note_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NOTE_D1 = 3'd1,
    NOTE_D2 = 3'd2,
    SKIP_D1 = 3'd3,
    SKIP_D2 = 3'd4,
    SYSEX   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  rs_valid_q, rs_valid_d;
  logic [3:0]            rs_kind_q, rs_kind_d;
  logic [3:0]            rs_channel_q, rs_channel_d;
  logic [DATA_WIDTH-1:0] note_number_q, note_number_d;
  note_change_t          note_q, note_d;
  logic                  note_ready_q, note_ready_d;

  byte_class_e           byte_class;
  logic [3:0]            byte_kind;
  logic [3:0]            byte_channel;
  logic [1:0]            byte_data_count;
  logic                  channel_match;

  midi_byte_classifier u_classifier (
    .byte_in    (byte_in),
    .byte_class (byte_class),
    .kind       (byte_kind),
    .channel    (byte_channel),
    .data_count (byte_data_count)
  );

`ifdef MIDI_CHANNEL_FILTER_EN
  assign channel_match = (rs_channel_q == CHANNEL[3:0]);
`else
  // Omni: every channel emits; the compare only keeps CHANNEL referenced.
  assign channel_match = 1'b1 | (rs_channel_q == CHANNEL[3:0]);
`endif

  // Next-state logic. Nothing changes without byte_valid, and real-time
  // bytes fall through untouched so they can sit inside any message.
  always_comb begin
    state_d       = state_q;
    rs_valid_d    = rs_valid_q;
    rs_kind_d     = rs_kind_q;
    rs_channel_d  = rs_channel_q;
    note_number_d = note_number_q;
    note_d        = note_q;
    note_ready_d  = 1'b0;
    if (byte_valid) begin
      case (byte_class)
        BC_VOICE: begin
          rs_valid_d   = 1'b1;
          rs_kind_d    = byte_kind;
          rs_channel_d = byte_channel;
          if (is_note_kind(byte_kind)) begin
            state_d = NOTE_D1;
          end else if (byte_data_count == 2'd2) begin
            state_d = SKIP_D2;
          end else begin
            state_d = SKIP_D1;
          end
        end
        BC_SYSCOM: begin
          // Any system common byte (including F7) clears running status;
          // the skip states then return to IDLE because rs_valid is clear.
          rs_valid_d = 1'b0;
          if (byte_in == SYSEX_START) begin
            state_d = SYSEX;
          end else if (byte_data_count == 2'd2) begin
            state_d = SKIP_D2;
          end else if (byte_data_count == 2'd1) begin
            state_d = SKIP_D1;
          end else begin
            state_d = IDLE;
          end
        end
        BC_DATA: begin
          case (state_q)
            NOTE_D1: begin
              note_number_d = byte_in[6:0];
              state_d       = NOTE_D2;
            end
            NOTE_D2: begin
              state_d = NOTE_D1;
              if (channel_match) begin
                note_ready_d         = 1'b1;
                note_d.note_number   = note_number_q;
                note_d.velocity      = byte_in[6:0];
                note_d.status        = ((rs_kind_q == NOTE_ON) && (byte_in[6:0] != '0)) ? ON : OFF;
              end
            end
            SKIP_D2: state_d = SKIP_D1;
            SKIP_D1: begin
              if (!rs_valid_q) begin
                state_d = IDLE;
              end else if (voice_data_count(rs_kind_q) == 2'd2) begin
                state_d = SKIP_D2;
              end else begin
                state_d = SKIP_D1;
              end
            end
            default: state_d = state_q;
          endcase
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_q       <= IDLE;
      rs_valid_q    <= 1'b0;
      rs_kind_q     <= 4'h0;
      rs_channel_q  <= 4'h0;
      note_number_q <= '0;
      note_q        <= '0;
      note_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rs_valid_q    <= rs_valid_d;
      rs_kind_q     <= rs_kind_d;
      rs_channel_q  <= rs_channel_d;
      note_number_q <= note_number_d;
      note_q        <= note_d;
      note_ready_q  <= note_ready_d;
    end
  end

  assign note       = note_q;
  assign note_ready = note_ready_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Testbench for midi_note_decoder: directed byte sequences with hand-computed
// note events; strobes are counted by a monitor sampling on the falling edge.
module tb_midi_note_decoder;
  import MIDI::*;

  logic         clk;
  logic         reset;
  logic [7:0]   byte_in;
  logic         byte_valid;
  note_change_t note;
  logic         note_ready;

  int assert_count;
  int fail_count;
  int strobe_count;
  logic [14:0] last_note;

  midi_note_decoder #(.CHANNEL(0)) dut (
    .clock_50_000_000 (clk),
    .reset            (reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .note             (note),
    .note_ready       (note_ready)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Strobe monitor: note_ready is high for one full period, so exactly one
  // falling edge sees each strobe.
  always @(negedge clk) begin
    if (note_ready) begin
      strobe_count <= strobe_count + 1;
      last_note    <= note;
    end
  end

  function automatic logic [14:0] exp_note(input logic on, input logic [6:0] num, input logic [6:0] vel);
    return {on, num, vel};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One byte per call; valid is dropped #1 after the accepting edge so
  // consecutive calls still present bytes on consecutive clock edges.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clearStrobes();
    @(negedge clk);
    #1;
    strobe_count = 0;
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    strobe_count = 0;
    last_note    = '0;
    reset        = 1'b1;
    byte_in      = 8'h00;
    byte_valid   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_note", {17'd0, note}, 32'd0);
    checkOutput("reset_ready", {31'd0, note_ready}, 32'd0);
    reset = 1'b0;
    idleCycles(2);
    checkOutput("idle_after_reset", {31'd0, note_ready}, 32'd0);

    // Basic Note On, latency one clock after velocity byte
    clearStrobes();
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    checkOutput("t1_no_early_strobe", {31'd0, note_ready}, 32'd0);
    applyStimulus(8'h64);
    checkOutput("t1_strobe", {31'd0, note_ready}, 32'd1);
    checkOutput("t1_note", {17'd0, note}, {17'd0, exp_note(1'b1, 7'd60, 7'd100)});
    idleCycles(3);
    checkOutput("t1_strobe_drop", {31'd0, note_ready}, 32'd0);
    checkOutput("t1_note_hold", {17'd0, note}, {17'd0, exp_note(1'b1, 7'd60, 7'd100)});
    checkOutput("t1_count", strobe_count, 32'd1);

    // Running status with velocity-0 Note On
    clearStrobes();
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    applyStimulus(8'h64);
    checkOutput("t2_first", {17'd0, note}, {17'd0, exp_note(1'b1, 7'd60, 7'd100)});
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    checkOutput("t2_second_strobe", {31'd0, note_ready}, 32'd1);
    checkOutput("t2_second", {17'd0, note}, {17'd0, exp_note(1'b0, 7'd64, 7'd0)});
    idleCycles(2);
    checkOutput("t2_count", strobe_count, 32'd2);

    // Real-time clock byte in the middle of a Note Off
    clearStrobes();
    applyStimulus(8'h80);
    applyStimulus(8'h3C);
    applyStimulus(8'hF8);
    checkOutput("t3_rt_no_strobe", {31'd0, note_ready}, 32'd0);
    applyStimulus(8'h40);
    checkOutput("t3_strobe", {31'd0, note_ready}, 32'd1);
    checkOutput("t3_note", {17'd0, note}, {17'd0, exp_note(1'b0, 7'd60, 7'd64)});
    idleCycles(2);
    checkOutput("t3_count", strobe_count, 32'd1);

    // CC and program change skipped, then Note On on channel 1
    clearStrobes();
    applyStimulus(8'hB0);
    applyStimulus(8'h07);
    applyStimulus(8'h7F);
    applyStimulus(8'hC0);
    applyStimulus(8'h05);
    applyStimulus(8'h91);
    applyStimulus(8'h45);
    applyStimulus(8'h50);
    idleCycles(2);
`ifdef MIDI_CHANNEL_FILTER_EN
    checkOutput("t4_count", strobe_count, 32'd0);
`else
    checkOutput("t4_count", strobe_count, 32'd1);
    checkOutput("t4_note", {17'd0, last_note}, {17'd0, exp_note(1'b1, 7'd69, 7'd80)});
`endif

    // SysEx aborted by a voice status, then a terminated SysEx
    clearStrobes();
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    applyStimulus(8'h90);
    applyStimulus(8'h34);
    applyStimulus(8'h35);
    checkOutput("t5_abort_note", {17'd0, note}, {17'd0, exp_note(1'b1, 7'h34, 7'h35)});
    applyStimulus(8'hF0);
    applyStimulus(8'h01);
    applyStimulus(8'hF7);
    applyStimulus(8'h3C);
    applyStimulus(8'h40);
    idleCycles(2);
    checkOutput("t5_count", strobe_count, 32'd1);
    checkOutput("t5_note_hold", {17'd0, note}, {17'd0, exp_note(1'b1, 7'h34, 7'h35)});

    // Song position clears running status: trailing data never decodes
    clearStrobes();
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    applyStimulus(8'h64);
    applyStimulus(8'hF2);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h3C);
    applyStimulus(8'h40);
    idleCycles(2);
    checkOutput("t6_count", strobe_count, 32'd1);

    // Reset in the middle of a message
    clearStrobes();
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    pulseReset();
    applyStimulus(8'h64);
    checkOutput("t7_no_strobe", {31'd0, note_ready}, 32'd0);
    idleCycles(2);
    checkOutput("t7_note_cleared", {17'd0, note}, 32'd0);
    checkOutput("t7_count", strobe_count, 32'd0);

    // Channel 1 Note On: filtered out when the channel filter is built in
    clearStrobes();
    applyStimulus(8'h91);
    applyStimulus(8'h3C);
    applyStimulus(8'h64);
    idleCycles(2);
`ifdef MIDI_CHANNEL_FILTER_EN
    checkOutput("t8_count", strobe_count, 32'd0);
`else
    checkOutput("t8_count", strobe_count, 32'd1);
    checkOutput("t8_note", {17'd0, last_note}, {17'd0, exp_note(1'b1, 7'd60, 7'd100)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
